// File: rtl/avalon_st_checker_ctrl_pkg.sv
// Shared types and constants for the Avalon-ST checker run controller.
package avalon_st_checker_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETTLE,
        ST_RUN,
        ST_RD_SAMP,
        ST_WAIT_SAMP,
        ST_RD_OK,
        ST_WAIT_OK,
        ST_FINISH
    } state_t;

    localparam logic [3:0] CSR_ID          = 4'd0;
    localparam logic [3:0] CSR_VERSION     = 4'd1;
    localparam logic [3:0] CSR_SCRATCH     = 4'd2;
    localparam logic [3:0] CSR_CTRL        = 4'd3;
    localparam logic [3:0] CSR_STATUS      = 4'd4;
    localparam logic [3:0] CSR_WINDOW      = 4'd5;
    localparam logic [3:0] CSR_RES_SAMPLES = 4'd6;
    localparam logic [3:0] CSR_RES_OK      = 4'd7;
    localparam logic [3:0] CSR_RUN_CNT     = 4'd8;

    localparam logic [31:0] ID_VALUE       = 32'h5E9C_7C1A;
    localparam logic [31:0] VERSION_VALUE  = 32'h0000_0100;
    localparam logic [31:0] UNMAPPED_VALUE = 32'hDEAD_BEEF;

    // Stream-checker register map; the clear and sample counter share address 4.
    localparam int unsigned CHK_REG_CLEAR   = 4;
    localparam int unsigned CHK_REG_SAMPLES = 4;
    localparam int unsigned CHK_REG_OK      = 5;

endpackage

// File: rtl/avalon_st_checker_ctrl.sv
// CSR-controlled sequencer that clears a stream checker, waits a sample window,
// then reads back the sample and ok counters and reports pass/fail.
//
// state      | meaning
// IDLE       | waiting for START
// CLEAR      | write 1 to checker clear register
// SETTLE     | 2 cycles for the checker's registered clear
// RUN        | WINDOW cycles of traffic observation
// RD_SAMP    | read request for sample count
// WAIT_SAMP  | capture sample count
// RD_OK      | read request for ok count
// WAIT_OK    | capture ok count
// FINISH     | set DONE/PASS, bump RUN_CNT
module avalon_st_checker_ctrl
    import avalon_st_checker_ctrl_pkg::*;
#(
    parameter int CHK_ADDR_W = 4
) (
    input  logic                  csi_clk_clk,
    input  logic                  rsi_reset_reset,
    input  logic [3:0]            avs_ctrl_address,
    input  logic                  avs_ctrl_read,
    input  logic                  avs_ctrl_write,
    input  logic [31:0]           avs_ctrl_writedata,
    output logic [31:0]           avs_ctrl_readdata,
    output logic [CHK_ADDR_W-1:0] avm_chk_address,
    output logic                  avm_chk_read,
    output logic                  avm_chk_write,
    output logic [31:0]           avm_chk_writedata,
    input  logic [31:0]           avm_chk_readdata,
    output logic                  ins_irq_irq
);

    state_t      state_q, state_nxt;
    logic        settle_q;
    logic [31:0] run_ctr_q;
    logic [31:0] scratch_q, window_q, res_samples_q, res_ok_q, run_cnt_q;
    logic        irq_en_q, done_q, pass_q;
    logic [31:0] rd_mux;

    logic wr_ctrl, start_req, abort_req, start_go, abort_go, busy;

    assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == CSR_CTRL);
    assign start_req = wr_ctrl && avs_ctrl_writedata[0] && !avs_ctrl_writedata[1];
    assign abort_req = wr_ctrl && avs_ctrl_writedata[1];
    assign busy      = (state_q != ST_IDLE);
    assign start_go  = !busy && start_req;
    assign abort_go  = busy && abort_req;

    always_ff @(posedge csi_clk_clk) begin
        if (rsi_reset_reset) begin
            state_q   <= ST_IDLE;
            settle_q  <= 1'b0;
            run_ctr_q <= '0;
        end else begin
            state_q  <= state_nxt;
            settle_q <= (state_q == ST_SETTLE) && !settle_q;
            if (start_go)
                run_ctr_q <= window_q;
            else if (state_q == ST_RUN)
                run_ctr_q <= run_ctr_q - 32'd1;
        end
    end

    always_comb begin
        state_nxt         = state_q;
        avm_chk_read      = 1'b0;
        avm_chk_write     = 1'b0;
        avm_chk_address   = '0;
        avm_chk_writedata = '0;
        case (state_q)
            ST_IDLE:      if (start_go) state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                avm_chk_write     = 1'b1;
                avm_chk_address   = CHK_ADDR_W'(CHK_REG_CLEAR);
                avm_chk_writedata = 32'd1;
                state_nxt         = ST_SETTLE;
            end
            ST_SETTLE:
                if (settle_q) state_nxt = (run_ctr_q == 32'd0) ? ST_RD_SAMP : ST_RUN;
            ST_RUN:       if (run_ctr_q == 32'd1) state_nxt = ST_RD_SAMP;
            ST_RD_SAMP: begin
                avm_chk_read    = 1'b1;
                avm_chk_address = CHK_ADDR_W'(CHK_REG_SAMPLES);
                state_nxt       = ST_WAIT_SAMP;
            end
            ST_WAIT_SAMP: state_nxt = ST_RD_OK;
            ST_RD_OK: begin
                avm_chk_read    = 1'b1;
                avm_chk_address = CHK_ADDR_W'(CHK_REG_OK);
                state_nxt       = ST_WAIT_OK;
            end
            ST_WAIT_OK:   state_nxt = ST_FINISH;
            ST_FINISH:    state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
        if (abort_go) state_nxt = ST_IDLE;
    end

    always_comb begin
        rd_mux = UNMAPPED_VALUE;
        case (avs_ctrl_address)
            CSR_ID:          rd_mux = ID_VALUE;
            CSR_VERSION:     rd_mux = VERSION_VALUE;
            CSR_SCRATCH:     rd_mux = scratch_q;
            CSR_CTRL:        rd_mux = {29'd0, irq_en_q, 2'b00};
            CSR_STATUS:      rd_mux = {29'd0, pass_q, done_q, busy};
            CSR_WINDOW:      rd_mux = window_q;
            CSR_RES_SAMPLES: rd_mux = res_samples_q;
            CSR_RES_OK:      rd_mux = res_ok_q;
            CSR_RUN_CNT:     rd_mux = run_cnt_q;
            default:         rd_mux = UNMAPPED_VALUE;
        endcase
    end

    always_ff @(posedge csi_clk_clk) begin
        if (rsi_reset_reset) begin
            scratch_q         <= '0;
            window_q          <= '0;
            res_samples_q     <= '0;
            res_ok_q          <= '0;
            run_cnt_q         <= '0;
            irq_en_q          <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            avs_ctrl_readdata <= '0;
        end else begin
            if (avs_ctrl_read) avs_ctrl_readdata <= rd_mux;
            if (avs_ctrl_write) begin
                case (avs_ctrl_address)
                    CSR_SCRATCH: scratch_q <= avs_ctrl_writedata;
                    CSR_CTRL:    irq_en_q  <= avs_ctrl_writedata[2];
                    CSR_STATUS:  if (avs_ctrl_writedata[1]) done_q <= 1'b0;
                    CSR_WINDOW:  window_q  <= avs_ctrl_writedata;
                    default: ;
                endcase
            end
            if (start_go) begin
                done_q <= 1'b0;
                pass_q <= 1'b0;
            end
            if (!abort_go) begin
                if (state_q == ST_WAIT_SAMP) res_samples_q <= avm_chk_readdata;
                if (state_q == ST_WAIT_OK)   res_ok_q      <= avm_chk_readdata;
                // Placed after the CSR clear so a coincident DONE-clear loses.
                if (state_q == ST_FINISH) begin
                    done_q    <= 1'b1;
                    pass_q    <= (res_samples_q != 32'd0) && (res_ok_q == res_samples_q);
                    run_cnt_q <= run_cnt_q + 32'd1;
                end
            end
        end
    end

    assign ins_irq_irq = done_q && irq_en_q;

endmodule

// File: tb/tb_avalon_st_checker_ctrl.sv
// Directed bench for the checker run controller: CSR vector table plus
// hand-written run, abort, wrap and mid-run reset sequences.
module tb_avalon_st_checker_ctrl;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    localparam int N_RST = 11;
    localparam int N_VEC = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_wdata, avs_rdata;
    logic [3:0]  chk_addr;
    logic        chk_read, chk_write;
    logic [31:0] chk_wdata;
    logic [31:0] chk_rdata;
    logic        irq;

    logic [31:0] mdl_samples, mdl_ok;

    int cyc = 0;
    int n_wr = 0, n_rd = 0, proto_err = 0;
    int last_wr_cyc = -1, last_samp_cyc = -1, last_ok_cyc = -1;
    logic [3:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    int total = 0;
    int bad = 0;

    vec_t vecs [N_VEC];

    always #5 clk = ~clk;

    avalon_st_checker_ctrl #(.CHK_ADDR_W(4)) dut (
        .csi_clk_clk        (clk),
        .rsi_reset_reset    (rst),
        .avs_ctrl_address   (avs_address),
        .avs_ctrl_read      (avs_read),
        .avs_ctrl_write     (avs_write),
        .avs_ctrl_writedata (avs_wdata),
        .avs_ctrl_readdata  (avs_rdata),
        .avm_chk_address    (chk_addr),
        .avm_chk_read       (chk_read),
        .avm_chk_write      (chk_write),
        .avm_chk_writedata  (chk_wdata),
        .avm_chk_readdata   (chk_rdata),
        .ins_irq_irq        (irq)
    );

    // Checker model with read latency 1, plus access monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        chk_rdata <= 32'd0;
        if (chk_read) chk_rdata <= (chk_addr == 4'd4) ? mdl_samples : mdl_ok;
        if (chk_write) begin
            n_wr         <= n_wr + 1;
            last_wr_cyc  <= cyc;
            last_wr_addr <= chk_addr;
            last_wr_data <= chk_wdata;
        end
        if (chk_read) begin
            n_rd <= n_rd + 1;
            if (chk_addr == 4'd4) last_samp_cyc <= cyc;
            if (chk_addr == 4'd5) last_ok_cyc   <= cyc;
        end
        if (chk_read && chk_write)
            proto_err <= proto_err + 1;
        else if (!chk_read && !chk_write && (chk_addr != 4'd0 || chk_wdata != 32'd0))
            proto_err <= proto_err + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int target);
        if (cyc > target) check("tick_to", 32'(cyc), 32'(target));
        while (cyc < target) tick();
    endtask

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        avs_address = a;
        avs_wdata   = d;
        avs_write   = 1'b1;
        tick();
        avs_write   = 1'b0;
        avs_address = '0;
        avs_wdata   = '0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        avs_address = '0;
        d = avs_rdata;
    endtask

    task automatic run_vec(input int i);
        logic [31:0] d;
        if (vecs[i].wr) csr_write(vecs[i].addr, vecs[i].data);
        else begin
            csr_read(vecs[i].addr, d);
            check($sformatf("vec%0d_a%0d", i, vecs[i].addr), d, vecs[i].exp);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int s, w0, r0;

        vecs[0]  = '{0, 4'd0,  32'h0, 32'h5E9C_7C1A};
        vecs[1]  = '{0, 4'd1,  32'h0, 32'h0000_0100};
        vecs[2]  = '{0, 4'd2,  32'h0, 32'h0};
        vecs[3]  = '{0, 4'd3,  32'h0, 32'h0};
        vecs[4]  = '{0, 4'd4,  32'h0, 32'h0};
        vecs[5]  = '{0, 4'd5,  32'h0, 32'h0};
        vecs[6]  = '{0, 4'd6,  32'h0, 32'h0};
        vecs[7]  = '{0, 4'd7,  32'h0, 32'h0};
        vecs[8]  = '{0, 4'd8,  32'h0, 32'h0};
        vecs[9]  = '{0, 4'd9,  32'h0, 32'hDEAD_BEEF};
        vecs[10] = '{0, 4'd15, 32'h0, 32'hDEAD_BEEF};
        vecs[11] = '{1, 4'd2,  32'hA5A5_5A5A, 32'h0};
        vecs[12] = '{0, 4'd2,  32'h0, 32'hA5A5_5A5A};
        vecs[13] = '{1, 4'd3,  32'h4, 32'h0};
        vecs[14] = '{0, 4'd3,  32'h0, 32'h4};
        vecs[15] = '{1, 4'd3,  32'h0, 32'h0};
        vecs[16] = '{0, 4'd3,  32'h0, 32'h0};
        vecs[17] = '{1, 4'd4,  32'hFFFF_FFFD, 32'h0};
        vecs[18] = '{0, 4'd4,  32'h0, 32'h0};
        vecs[19] = '{1, 4'd6,  32'h1234, 32'h0};
        vecs[20] = '{0, 4'd6,  32'h0, 32'h0};
        vecs[21] = '{1, 4'd8,  32'h5, 32'h0};
        vecs[22] = '{0, 4'd8,  32'h0, 32'h0};
        vecs[23] = '{1, 4'd5,  32'd100, 32'h0};
        vecs[24] = '{0, 4'd5,  32'h0, 32'd100};

        rst = 1'b1;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_wdata = '0;
        mdl_samples = 32'd3200; mdl_ok = 32'd3200;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_readdata", avs_rdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_master", {chk_wdata[27:0], chk_addr}, 32'h0);

        for (int i = 0; i < N_VEC; i++) run_vec(i);

        // Full run with WINDOW=100, matching counts.
        w0 = n_wr; r0 = n_rd;
        s = cyc;
        csr_write(4'd3, 32'h1);
        csr_read(4'd4, d);
        check("r1_busy", d, 32'h1);
        tick_to(s + 109);
        check("r1_clear_cyc", 32'(last_wr_cyc - s), 32'd1);
        check("r1_clear_addr", {28'd0, last_wr_addr}, 32'd4);
        check("r1_clear_data", last_wr_data, 32'd1);
        check("r1_samp_cyc", 32'(last_samp_cyc - s), 32'd104);
        check("r1_ok_cyc", 32'(last_ok_cyc - s), 32'd106);
        check("r1_nwr", 32'(n_wr - w0), 32'd1);
        check("r1_nrd", 32'(n_rd - r0), 32'd2);
        csr_read(4'd4, d); check("r1_status", d, 32'h6);
        csr_read(4'd8, d); check("r1_run_cnt", d, 32'd1);
        csr_read(4'd6, d); check("r1_samples", d, 32'd3200);
        csr_read(4'd7, d); check("r1_ok", d, 32'd3200);

        // Mismatched counts with IRQ enabled.
        mdl_ok = 32'd3168;
        s = cyc;
        csr_write(4'd3, 32'h5);
        csr_read(4'd4, d); check("r2_start_clears", d, 32'h1);
        tick_to(s + 109);
        csr_read(4'd4, d); check("r2_status", d, 32'h2);
        csr_read(4'd7, d); check("r2_ok", d, 32'd3168);
        check("r2_irq_on", 32'(irq), 32'h1);
        csr_write(4'd4, 32'h2);
        check("r2_irq_off", 32'(irq), 32'h0);
        csr_read(4'd4, d); check("r2_status_clr", d, 32'h0);
        csr_read(4'd8, d); check("r2_run_cnt", d, 32'd2);

        // WINDOW=0 skips RUN; zero samples never pass.
        csr_write(4'd5, 32'd0);
        mdl_samples = 32'd0; mdl_ok = 32'd0;
        s = cyc;
        csr_write(4'd3, 32'h1);
        tick_to(s + 9);
        check("r3_clear_cyc", 32'(last_wr_cyc - s), 32'd1);
        check("r3_samp_cyc", 32'(last_samp_cyc - s), 32'd4);
        check("r3_ok_cyc", 32'(last_ok_cyc - s), 32'd6);
        csr_read(4'd4, d); check("r3_status", d, 32'h2);
        csr_read(4'd8, d); check("r3_run_cnt", d, 32'd3);

        // Abort mid-RUN, with an ignored second START before it.
        csr_write(4'd4, 32'h2);
        csr_write(4'd5, 32'd100);
        mdl_samples = 32'd5; mdl_ok = 32'd5;
        w0 = n_wr; r0 = n_rd;
        s = cyc;
        csr_write(4'd3, 32'h1);
        tick_to(s + 20);
        csr_write(4'd3, 32'h1);
        tick_to(s + 50);
        csr_write(4'd3, 32'h2);
        check("r4_strobes", {30'd0, chk_read, chk_write}, 32'h0);
        csr_read(4'd4, d); check("r4_status", d, 32'h0);
        repeat (10) tick();
        check("r4_nrd", 32'(n_rd - r0), 32'd0);
        check("r4_nwr", 32'(n_wr - w0), 32'd1);
        csr_read(4'd8, d); check("r4_run_cnt", d, 32'd3);

        // START and ABORT together in IDLE start nothing.
        w0 = n_wr;
        csr_write(4'd3, 32'h3);
        repeat (5) tick();
        csr_read(4'd4, d); check("r5_status", d, 32'h0);
        check("r5_nwr", 32'(n_wr - w0), 32'd0);

        // RUN_CNT wrap.
        force dut.run_cnt_q = 32'hFFFF_FFFF;
        csr_read(4'd8, d); check("r6_forced", d, 32'hFFFF_FFFF);
        release dut.run_cnt_q;
        csr_write(4'd5, 32'd0);
        mdl_samples = 32'd7; mdl_ok = 32'd7;
        s = cyc;
        csr_write(4'd3, 32'h1);
        tick_to(s + 9);
        csr_read(4'd8, d); check("r6_wrap", d, 32'h0);
        csr_read(4'd4, d); check("r6_status", d, 32'h6);
        csr_read(4'd6, d); check("r6_samples", d, 32'd7);

        // Reset asserted while RD_SAMP is on the bus.
        csr_write(4'd2, 32'h1357_9BDF);
        s = cyc;
        csr_write(4'd3, 32'h4 | 32'h1);
        tick_to(s + 4);
        check("r7_in_rd_samp", {27'd0, chk_addr, chk_read}, 32'h9);
        rst = 1'b1;
        tick();
        check("r7_strobes", {30'd0, chk_read, chk_write}, 32'h0);
        check("r7_readdata", avs_rdata, 32'h0);
        tick();
        rst = 1'b0;
        w0 = n_wr; r0 = n_rd;
        repeat (10) tick();
        check("r7_nrd", 32'(n_rd - r0), 32'd0);
        check("r7_nwr", 32'(n_wr - w0), 32'd0);
        check("r7_irq", 32'(irq), 32'h0);
        for (int i = 0; i < N_RST; i++) run_vec(i);

        check("proto", 32'(proto_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avalon_st_checker_ctrl.md
AVALON_ST_CHECKER_CTRL -- requirements
Module: avalon_st_checker_ctrl

Interface
REQ-001 SHALL have parameter CHK_ADDR_W, default 4, the checker control address width.
REQ-002 SHALL have port csi_clk_clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rsi_reset_reset, input, 1, the reset, which is synchronous and active-high.
REQ-004 SHALL have port avs_ctrl_address, input, 4, the CSR slave address.
REQ-005 SHALL have ports avs_ctrl_read and avs_ctrl_write, input, 1 each, the CSR slave strobes, with no waitrequest.
REQ-006 SHALL have ports avs_ctrl_writedata, input, 32, and avs_ctrl_readdata, output, 32, registered with read latency 1.
REQ-007 SHALL have port avm_chk_address, output, CHK_ADDR_W, the master address to the stream checker.
REQ-008 SHALL have ports avm_chk_read and avm_chk_write, output, 1 each, the master strobes, with no waitrequest.
REQ-009 SHALL have ports avm_chk_writedata, output, 32, and avm_chk_readdata, input, 32; checker read latency is fixed at 1.
REQ-010 SHALL have port ins_irq_irq, output, 1, asserted high while DONE is set and IRQ_EN=1.

Function
REQ-011 CSR map SHALL be as follows; unmapped addresses read 0xDEADBEEF.
- 0: ID 0x5E9C7C1A.
- 1: version 0x00000100.
- 2: scratch (RW).
- 3: CTRL: bit0 START (write-1 pulse), bit1 ABORT (write-1 pulse), bit2 IRQ_EN (RW).
- 4: STATUS (RO): bit0 BUSY, bit1 DONE, bit2 PASS; a write with bit1=1 clears DONE.
- 5: WINDOW cycles (RW).
- 6: RES_SAMPLES (RO).
- 7: RES_OK (RO).
- 8: RUN_CNT (RO).
REQ-012 FSM states SHALL be IDLE, CLEAR, SETTLE, RUN, RD_SAMP, WAIT_SAMP, RD_OK, WAIT_OK, FINISH.
REQ-013 A CTRL write with START=1 in IDLE SHALL enter CLEAR on that edge, latch WINDOW into a run counter, and clear DONE and PASS.
REQ-014 START while not IDLE SHALL be ignored.
REQ-015 CLEAR SHALL last 1 cycle, driving avm_chk_write=1, address=4, writedata=1.
REQ-016 SETTLE SHALL last exactly 2 cycles with no master strobes, covering the checker's registered clear.
REQ-017 RUN SHALL last exactly WINDOW cycles; WINDOW=0 SHALL skip RUN, going SETTLE->RD_SAMP.
REQ-018 RD_SAMP SHALL last 1 cycle with avm_chk_read=1, address=4; WAIT_SAMP (1 cycle) SHALL capture avm_chk_readdata into RES_SAMPLES at its end.
REQ-019 RD_OK/WAIT_OK SHALL behave identically with address=5, capturing into RES_OK.
REQ-020 FINISH SHALL last 1 cycle.
- Sets DONE=1.
- Sets PASS=(RES_SAMPLES!=0 && RES_OK==RES_SAMPLES).
- Increments RUN_CNT modulo 2^32 (0xFFFFFFFF wraps to 0).
- Returns to IDLE.
REQ-021 ABORT=1 in any non-IDLE state SHALL force IDLE on that edge with master strobes low the next cycle, leaving DONE, PASS, RUN_CNT and results unchanged.
REQ-022 When START and ABORT are written together, ABORT SHALL win; in IDLE, nothing starts.
REQ-023 WINDOW writes during a run SHALL take effect only at the next START.
REQ-024 BUSY SHALL be 1 in every state except IDLE.
REQ-025 avm_chk_read and avm_chk_write SHALL never be high in the same cycle; outside CLEAR/RD_* both SHALL be 0, with address and writedata 0.
REQ-026 A DONE-clear write coincident with FINISH SHALL leave DONE=1 (set wins).

Reset
REQ-027 Reset SHALL put the FSM in IDLE.
REQ-028 Reset SHALL zero all master outputs, scratch, CTRL.IRQ_EN, DONE, PASS, WINDOW, RES_SAMPLES, RES_OK, RUN_CNT and ins_irq_irq.
REQ-029 avs_ctrl_readdata SHALL be 0 after reset.
REQ-030 Reset mid-run SHALL deassert master strobes on the same edge, with no checker access afterwards.

Structure
REQ-031 Package avalon_st_checker_ctrl_pkg SHALL hold:
- the state enum;
- CSR address constants;
- ID and version constants;
- checker register addresses (clear/samples=4, ok=5).
REQ-032 The block SHALL be a single module with no sub-module.

Verification
REQ-033 WINDOW=100, START, checker model returns 3200/3200: CLEAR write at cycle 1; RD_SAMP at cycle 104; DONE=1, PASS=1, RUN_CNT=1, BUSY=0 by cycle 109.
REQ-034 Checker model returns 3200/3168: PASS=0, RES_OK=3168; with IRQ_EN=1, irq=1 until the DONE-clear write.
REQ-035 WINDOW=0, START: no RUN cycles; reads occur 3 cycles after CLEAR; checker returns 0/0, so PASS=0.
REQ-036 ABORT during RUN at cycle 50: IDLE next edge; no master reads; DONE=0 and RUN_CNT unchanged; a second START during the run is ignored.
REQ-037 RUN_CNT preloaded to 0xFFFFFFFF via force, one run: RUN_CNT=0; reset asserted mid-RD_SAMP: strobes low the same edge and all CSRs at reset values.
